// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package addsub_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int   SLICE_W = 4;
   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/add4b.sv
// 4-bit adder-subtractor slice: s = a + (b ^ {4{sub}}) + cin; carry-out on c_o.
module add4b (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       sub_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);

   logic [3:0] w_b_inv;

   assign w_b_inv    = b_i ^ {4{sub_i}};
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, w_b_inv} + {4'b0000, c_i};

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial A+B / A-B through one shared add4b; done_o NIBBLES+1 cycles after accept, ready_o only in IDLE.
// Requests outside IDLE are dropped, not queued. ADDSUB_SEQ_FLAGS_EN enables the z_o/v_o flag logic.
module addsub_seq_ctrl
   import addsub_seq_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic                         sub_i,
   input  logic [SLICE_W*NIBBLES-1:0]   a_i,
   input  logic [SLICE_W*NIBBLES-1:0]   b_i,
   output logic                         ready_o,
   output logic                         done_o,
   output logic [SLICE_W*NIBBLES-1:0]   s_o,
   output logic                         c_o,
   output logic                         z_o,
   output logic                         v_o
);

   localparam int W  = SLICE_W * NIBBLES;
   localparam int KW = $clog2(NIBBLES);
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   state_t          r_state;
   logic [KW-1:0]   r_k;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic            r_sub;
   logic            r_cy;
   logic [W-1:0]    r_acc;
   logic [W-1:0]    r_s;
   logic            r_c;
   logic            r_done;

   logic [KW+1:0]   w_base;
   logic [3:0]      w_sum;
   logic            w_co;
   logic [W-1:0]    w_acc_nxt;

   assign w_base = {r_k, 2'b00};

   add4b u_add4b (
      .a_i   (r_a[w_base +: SLICE_W]),
      .b_i   (r_b[w_base +: SLICE_W]),
      .sub_i (r_sub),
      .c_i   (r_cy),
      .s_o   (w_sum),
      .c_o   (w_co)
   );

   // Accumulator with the current slice merged, so DONE can load the full result on the last RUN edge.
   always_comb begin
      w_acc_nxt = r_acc;
      w_acc_nxt[w_base +: SLICE_W] = w_sum;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= OP_ADD;
         r_cy    <= 1'b0;
         r_acc   <= '0;
         r_s     <= '0;
         r_c     <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_a     <= a_i;
                  r_b     <= b_i;
                  r_sub   <= sub_i;
                  r_cy    <= sub_i;
                  r_k     <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_acc <= w_acc_nxt;
               r_cy  <= w_co;
               if (r_k == K_LAST) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_s     <= w_acc_nxt;
                  r_c     <= w_co;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef ADDSUB_SEQ_FLAGS_EN
   logic r_z;
   logic r_v;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_z <= 1'b0;
         r_v <= 1'b0;
      end else if (r_state == ST_RUN && r_k == K_LAST) begin
         r_z <= ~|w_acc_nxt;
         r_v <= ~(r_a[W-1] ^ (r_b[W-1] ^ r_sub)) & (r_a[W-1] ^ w_acc_nxt[W-1]);
      end
   end

   assign z_o = r_z;
   assign v_o = r_v;
`else
   assign z_o = 1'b0;
   assign v_o = 1'b0;
`endif

   assign ready_o = (r_state == ST_IDLE);
   assign done_o  = r_done;
   assign s_o     = r_s;
   assign c_o     = r_c;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Randomized self-checking bench for addsub_seq_ctrl (NIBBLES=4) against an arithmetic reference model.
module tb_addsub_seq_ctrl;

   localparam int N = 4;
   localparam int W = 16;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready;
   logic         done;
   logic [W-1:0] s;
   logic         c;
   logic         z;
   logic         v;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] prev_s = '0;
   logic         prev_c = 1'b0;

   addsub_seq_ctrl #(.NIBBLES(N)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .sub_i   (sub),
      .a_i     (a),
      .b_i     (b),
      .ready_o (ready),
      .done_o  (done),
      .s_o     (s),
      .c_o     (c),
      .z_o     (z),
      .v_o     (v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the whole operands.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                        output logic [W-1:0] es, output logic ec, output logic ez, output logic ev);
      int ua, ub, sa, sb, ideal;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (msub) begin
         es    = W'(ua - ub);
         ec    = (ua >= ub);
         ideal = sa - sb;
      end else begin
         es    = W'(ua + ub);
         ec    = ((ua + ub) > 65535);
         ideal = sa + sb;
      end
`ifdef ADDSUB_SEQ_FLAGS_EN
      ez = (es == '0);
      ev = (ideal > 32767) || (ideal < -32768);
`else
      ez = 1'b0;
      ev = 1'b0;
`endif
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                         input bit scramble);
      logic [W-1:0] es;
      logic         ec, ez, ev;
      int           cyc;
      bit           seen;
      model(ta, tb_v, tsub, es, ec, ez, ev);
      cyc = 0;
      while (!ready && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("ready_idle", ready, 1);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      sub   = tsub;
      cyc   = 0;
      seen  = 0;
      while (!seen && cyc < N + 6) begin
         @(posedge clk); #1;
         cyc++;
         chk("ready_busy", ready, 0);
         if (done) seen = 1;
         else if (cyc == 1) begin
            chk("hold_s", s, prev_s);
            chk("hold_c", c, prev_c);
         end
         if (scramble) begin
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("done_seen", seen, 1);
      chk("latency", cyc, N + 1);
      chk("s", s, es);
      chk("c", c, ec);
      chk("z", z, ez);
      chk("v", v, ev);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("ready_after", ready, 1);
      chk("s_held", s, es);
      prev_s = es;
      prev_c = ec;
   endtask

   task automatic reset_abort();
      chk("ra_ready", ready, 1);
      start = 1'b1;
      a     = 16'h1111;
      b     = 16'h2222;
      sub   = 1'b0;
      @(posedge clk); #1;          // accepted, RUN k=0
      start = 1'b1;
      @(posedge clk); #1;          // RUN k=1
      @(posedge clk); #1;          // RUN k=2
      chk("ra_busy", ready, 0);
      start = 1'b0;
      rst   = 1'b1;
      @(posedge clk); #1;
      chk("ra_done", done, 0);
      chk("ra_s", s, 0);
      chk("ra_c", c, 0);
      chk("ra_z", z, 0);
      chk("ra_v", v, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ra_ready_after", ready, 1);
      chk("ra_no_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("ra_quiet", done, 0);
      end
      prev_s = '0;
      prev_c = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("rst_done", done, 0);
      chk("rst_s", s, 0);
      chk("rst_c", c, 0);
      chk("rst_z", z, 0);
      chk("rst_v", v, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", ready, 1);

      run_op(16'h1234, 16'h0FFF, 1'b0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b1, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0);
      run_op(16'h0003, 16'h0004, 1'b0, 1);
      run_op(16'h0005, 16'h0005, 1'b1, 1);
      reset_abort();
      for (int i = 0; i < 40; i++) begin
         run_op(pick(), pick(), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
